filter_tx_server: RTL and testbench
===================================

FILTER_TX_SERVER -- requirements
Module: filter_tx_server

Parameters
REQ-001 The block SHALL have parameter DATA_WIDTH, default 32, meaning the data bus width.
REQ-002 The block SHALL have parameter L2_AWIDTH_NOAL, default 15, meaning the byte address width.

Interface
REQ-003 The block SHALL have `clk_i`, input, width 1: single clock, rising edge.
REQ-004 The block SHALL have `rst_i`, input, width 1: reset, asynchronous and active-high.
REQ-005 The block SHALL have `clear_i`, input, width 1: synchronous flush.
REQ-006 For each channel N in {0,1}, the block SHALL have `chN_req_i`, input, width 1: read request.
REQ-007 For each channel N, the block SHALL have `chN_addr_i`, input, width L2_AWIDTH_NOAL: byte address.
REQ-008 For each channel N, the block SHALL have `chN_datasize_i`, input, width 2: 00 byte, 01 half, 10/11 word.
REQ-009 For each channel N, the block SHALL have `chN_gnt_o`, output, width 1: request accepted.
REQ-010 For each channel N, the block SHALL have `chN_valid_o`, output, width 1: response data valid.
REQ-011 For each channel N, the block SHALL have `chN_data_o`, output, width DATA_WIDTH: aligned, zero-extended data.
REQ-012 For each channel N, the block SHALL have `chN_ready_i`, input, width 1: consumer accepts data.
REQ-013 The block SHALL have `mem_req_o`, output, width 1: L2 read request.
REQ-014 The block SHALL have `mem_addr_o`, output, width L2_AWIDTH_NOAL-2: word address.
REQ-015 The block SHALL have `mem_gnt_i`, input, width 1: L2 request accepted.
REQ-016 The block SHALL have `mem_rvalid_i`, input, width 1: L2 read data valid.
REQ-017 The block SHALL have `mem_rdata_i`, input, width DATA_WIDTH: L2 read word.
REQ-018 The block SHALL have `busy_o`, output, width 1: transaction in flight or any FIFO non-empty.

Function
REQ-019 The FSM SHALL have states IDLE, ISSUE and WAIT, with at most one memory transaction outstanding in total.
REQ-020 Each channel SHALL have a 2-entry response FIFO; channel N is eligible when `chN_req_i`=1 and its FIFO count < 2.
REQ-021 In IDLE with at least one eligible channel, the block SHALL assert `chN_gnt_o` combinationally for exactly one cycle for the selected channel only.
REQ-022 In that same cycle the block SHALL latch the address, datasize and channel id, and the FSM SHALL go to ISSUE.
REQ-023 Arbitration SHALL be round-robin: when both channels are eligible, the channel not granted last wins; a single eligible channel wins regardless of the pointer.
REQ-024 In ISSUE, `mem_req_o`=1 and `mem_addr_o`=latched_addr[L2_AWIDTH_NOAL-1:2], held stable until `mem_gnt_i`=1; then the FSM SHALL go to WAIT.
REQ-025 In WAIT, on `mem_rvalid_i`=1 the block SHALL push the aligned word into the latched channel's FIFO and go to IDLE; `mem_rvalid_i` outside WAIT SHALL be ignored.
REQ-026 Minimum grant-to-grant spacing SHALL be 3 cycles (IDLE, ISSUE, WAIT), with no grant while in ISSUE or WAIT.
REQ-027 Alignment SHALL be: byte = {24'b0, rdata[8*a[1:0] +: 8]}; half = {16'b0, rdata[16*a[1] +: 16]}; word = rdata unchanged; a = latched_addr[1:0].
REQ-028 `chN_valid_o` SHALL equal FIFO non-empty, and `chN_data_o` SHALL equal the FIFO head.
REQ-029 A FIFO pop SHALL occur on `chN_valid_o` & `chN_ready_i`; `chN_data_o` SHALL be stable while valid and not ready.
REQ-030 A push and a pop in the same cycle SHALL leave the count unchanged and keep order.
REQ-031 A push to a full FIFO SHALL be impossible by construction (eligibility is checked at grant).
REQ-032 `clear_i`=1 SHALL empty both FIFOs and suppress grants that cycle.
REQ-033 `clear_i` in ISSUE SHALL keep `mem_req_o` asserted until `mem_gnt_i` (an issued request cannot be retracted), and the data of that transaction SHALL be discarded on return.
REQ-034 `clear_i` in WAIT SHALL cause the returning data to be discarded.
REQ-035 `busy_o` SHALL be 1 when state != IDLE or any FIFO count != 0.

Reset
REQ-036 On `rst_i`=1, asynchronously: state = IDLE, FIFOs empty, round-robin pointer = "ch1 last", so ch0 wins first.
REQ-037 On `rst_i`=1, asynchronously: all gnt/valid/`mem_req_o`/`busy_o` = 0 and all data/address outputs = 0.
REQ-038 Reset mid-transaction SHALL abandon the transaction; a late `mem_rvalid_i` after reset release SHALL be ignored, because the FSM is in IDLE.

Verification
REQ-039 Byte read: ch0 addr 200, size 00, memory word 0x44332211 -> `mem_addr_o`=50, `ch0_data_o`=0x00000011, then word 202 size 01 -> 0x00004433.
REQ-040 Both channels request at the same time after reset -> ch0 granted first, ch1 next; with both held high, grants alternate 0,1,0,1.
REQ-041 Back-pressure: `ch0_ready_i`=0 with 3 requests -> exactly 2 grants; the third grant occurs only after one pop.
REQ-042 `mem_gnt_i` delayed 4 cycles -> `mem_req_o` and `mem_addr_o` held stable for all 4 cycles; no new grant is issued.
REQ-043 `clear_i` pulse in WAIT with 1 entry already buffered -> both FIFOs empty; the returning word is discarded; `busy_o`=0 one cycle after return.
REQ-044 `rst_i` asserted in ISSUE -> `mem_req_o`=0 immediately (asynchronous); after release, a stray `mem_rvalid_i` produces no valid output.

Source files
------------

// File: rtl/filter_tx_server.sv
// Two-channel L2 read server: round-robin arbitration, one outstanding memory read,
// byte/half/word alignment and a 2-entry response FIFO per channel.
module filter_tx_server #(
  parameter int DATA_WIDTH     = 32,
  parameter int L2_AWIDTH_NOAL = 15
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic                      clear_i,

  input  logic                      ch0_req_i,
  input  logic [L2_AWIDTH_NOAL-1:0] ch0_addr_i,
  input  logic [1:0]                ch0_datasize_i,
  output logic                      ch0_gnt_o,
  output logic                      ch0_valid_o,
  output logic [DATA_WIDTH-1:0]     ch0_data_o,
  input  logic                      ch0_ready_i,

  input  logic                      ch1_req_i,
  input  logic [L2_AWIDTH_NOAL-1:0] ch1_addr_i,
  input  logic [1:0]                ch1_datasize_i,
  output logic                      ch1_gnt_o,
  output logic                      ch1_valid_o,
  output logic [DATA_WIDTH-1:0]     ch1_data_o,
  input  logic                      ch1_ready_i,

  output logic                      mem_req_o,
  output logic [L2_AWIDTH_NOAL-3:0] mem_addr_o,
  input  logic                      mem_gnt_i,
  input  logic                      mem_rvalid_i,
  input  logic [DATA_WIDTH-1:0]     mem_rdata_i,

  output logic                      busy_o
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] ISSUE = 2'd1;
  localparam logic [1:0] WAIT  = 2'd2;

  logic [1:0]                state_q;
  logic [L2_AWIDTH_NOAL-1:0] addr_q;
  logic [1:0]                size_q;
  logic                      ch_q;
  logic                      last_q;
  logic                      discard_q;

  logic [DATA_WIDTH-1:0]     fifo_mem [2][2];
  logic [1:0]                rptr_q;
  logic [1:0]                wptr_q;
  logic [1:0]                cnt_q [2];

  logic [1:0]                req, ready, elig, gnt, valid, pop, push_ch;
  logic                      sel;
  logic                      push;
  logic [DATA_WIDTH-1:0]     aligned;

  always_comb begin
    req   = {ch1_req_i, ch0_req_i};
    ready = {ch1_ready_i, ch0_ready_i};
    elig  = '0;
    valid = '0;
    pop   = '0;
    for (int unsigned c = 0; c < 2; c++) begin
      elig[c]  = req[c] & (cnt_q[c] != 2'd2);
      valid[c] = (cnt_q[c] != 2'd0);
      pop[c]   = valid[c] & ready[c];
    end
    // last_q holds the channel granted most recently; the other one wins a tie
    sel = (elig == 2'b11) ? ~last_q : elig[1];
    gnt = '0;
    if (state_q == IDLE && !clear_i && !rst_i && elig != 2'b00)
      gnt[sel] = 1'b1;
  end

  always_comb begin
    aligned = mem_rdata_i;
    case (size_q)
      2'b00:   aligned = {{(DATA_WIDTH-8){1'b0}},  mem_rdata_i[{addr_q[1:0], 3'b000} +: 8]};
      2'b01:   aligned = {{(DATA_WIDTH-16){1'b0}}, mem_rdata_i[{addr_q[1], 4'b0000} +: 16]};
      default: aligned = mem_rdata_i;
    endcase
    push    = (state_q == WAIT) & mem_rvalid_i & ~discard_q & ~clear_i;
    push_ch = '0;
    if (push)
      push_ch[ch_q] = 1'b1;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q   <= IDLE;
      addr_q    <= '0;
      size_q    <= '0;
      ch_q      <= 1'b0;
      last_q    <= 1'b1;
      discard_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (gnt != 2'b00) begin
            addr_q    <= sel ? ch1_addr_i : ch0_addr_i;
            size_q    <= sel ? ch1_datasize_i : ch0_datasize_i;
            ch_q      <= sel;
            last_q    <= sel;
            discard_q <= 1'b0;
            state_q   <= ISSUE;
          end
        end
        ISSUE: begin
          if (clear_i)
            discard_q <= 1'b1;
          if (mem_gnt_i)
            state_q <= WAIT;
        end
        WAIT: begin
          if (clear_i)
            discard_q <= 1'b1;
          if (mem_rvalid_i) begin
            discard_q <= 1'b0;
            state_q   <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int unsigned c = 0; c < 2; c++) begin
        cnt_q[c]       <= '0;
        fifo_mem[c][0] <= '0;
        fifo_mem[c][1] <= '0;
      end
      rptr_q <= '0;
      wptr_q <= '0;
    end else if (clear_i) begin
      for (int unsigned c = 0; c < 2; c++)
        cnt_q[c] <= '0;
      rptr_q <= '0;
      wptr_q <= '0;
    end else begin
      for (int unsigned c = 0; c < 2; c++) begin
        if (push_ch[c]) begin
          fifo_mem[c][wptr_q[c]] <= aligned;
          wptr_q[c]              <= ~wptr_q[c];
        end
        if (pop[c])
          rptr_q[c] <= ~rptr_q[c];
        cnt_q[c] <= cnt_q[c] + 2'(push_ch[c]) - 2'(pop[c]);
      end
    end
  end

  assign ch0_gnt_o   = gnt[0];
  assign ch1_gnt_o   = gnt[1];
  assign ch0_valid_o = valid[0];
  assign ch1_valid_o = valid[1];
  assign ch0_data_o  = fifo_mem[0][rptr_q[0]];
  assign ch1_data_o  = fifo_mem[1][rptr_q[1]];
  assign mem_req_o   = (state_q == ISSUE);
  assign mem_addr_o  = addr_q[L2_AWIDTH_NOAL-1:2];
  assign busy_o      = (state_q != IDLE) | (cnt_q[0] != 2'd0) | (cnt_q[1] != 2'd0);

endmodule

// File: tb/tb_filter_tx_server.sv
// Directed bench for filter_tx_server: memory responder model, grant-time scoreboard
// of expected read data, and pop-time comparison on each channel.
module tb_filter_tx_server;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b1;
  logic        clear_i = 1'b0;
  logic        ch0_req_i = 1'b0, ch1_req_i = 1'b0;
  logic [14:0] ch0_addr_i = '0, ch1_addr_i = '0;
  logic [1:0]  ch0_datasize_i = '0, ch1_datasize_i = '0;
  logic        ch0_ready_i = 1'b1, ch1_ready_i = 1'b1;
  logic        ch0_gnt_o, ch1_gnt_o, ch0_valid_o, ch1_valid_o;
  logic [31:0] ch0_data_o, ch1_data_o;
  logic        mem_req_o;
  logic [12:0] mem_addr_o;
  logic        mem_gnt_i = 1'b0;
  logic        mem_rvalid_i;
  logic [31:0] mem_rdata_i = '0;
  logic        busy_o;

  logic        rsp_rvalid = 1'b0;
  logic        stray_rvalid = 1'b0;
  assign mem_rvalid_i = rsp_rvalid | stray_rvalid;

  int n_pass = 0, n_fail = 0, n_total = 0;
  int gnt_delay = 0, rsp_lat = 1, cyc = 0;
  int gcnt0 = 0, gcnt1 = 0;
  int glog_ch[$], glog_cyc[$];
  logic [31:0] exp_q0[$], exp_q1[$];

  filter_tx_server #(.DATA_WIDTH(32), .L2_AWIDTH_NOAL(15)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .clear_i(clear_i),
    .ch0_req_i(ch0_req_i), .ch0_addr_i(ch0_addr_i), .ch0_datasize_i(ch0_datasize_i),
    .ch0_gnt_o(ch0_gnt_o), .ch0_valid_o(ch0_valid_o), .ch0_data_o(ch0_data_o), .ch0_ready_i(ch0_ready_i),
    .ch1_req_i(ch1_req_i), .ch1_addr_i(ch1_addr_i), .ch1_datasize_i(ch1_datasize_i),
    .ch1_gnt_o(ch1_gnt_o), .ch1_valid_o(ch1_valid_o), .ch1_data_o(ch1_data_o), .ch1_ready_i(ch1_ready_i),
    .mem_req_o(mem_req_o), .mem_addr_o(mem_addr_o), .mem_gnt_i(mem_gnt_i),
    .mem_rvalid_i(mem_rvalid_i), .mem_rdata_i(mem_rdata_i), .busy_o(busy_o)
  );

  initial forever #5 clk_i = ~clk_i;
  initial forever begin @(posedge clk_i); cyc++; end
  initial begin #100000; $display("FAIL watchdog: simulation did not finish"); $fatal(1); end

  function automatic logic [31:0] mem_word(input logic [12:0] w);
    if (w == 13'd50) return 32'h44332211;
    return {8'(w), 8'(w ^ 13'h5A), 8'hC3, 8'(w * 13'd3)};
  endfunction

  function automatic logic [31:0] exp_align(input logic [14:0] a, input logic [1:0] sz);
    logic [31:0] w;
    w = mem_word(a[14:2]);
    if (sz == 2'b00) return (w >> (8 * int'(a[1:0]))) & 32'h0000_00FF;
    if (sz == 2'b01) return (w >> (16 * int'(a[1]))) & 32'h0000_FFFF;
    return w;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // memory responder: grant after gnt_delay cycles of mem_req_o, data rsp_lat cycles later
  initial begin
    int phase, cnt;
    logic [12:0] r_addr;
    phase = 0; cnt = 0; r_addr = '0;
    forever begin
      @(negedge clk_i);
      mem_gnt_i  = 1'b0;
      rsp_rvalid = 1'b0;
      if (rst_i) begin
        phase = 0; cnt = 0;
      end else if (phase == 0) begin
        if (mem_req_o) begin
          if (cnt >= gnt_delay) begin
            mem_gnt_i = 1'b1; r_addr = mem_addr_o; phase = 1; cnt = 0;
          end else cnt++;
        end
      end else begin
        if (cnt + 1 >= rsp_lat) begin
          rsp_rvalid = 1'b1; mem_rdata_i = mem_word(r_addr); phase = 0; cnt = 0;
        end else cnt++;
      end
    end
  end

  // grant monitor: expected data enters the scoreboard when a request is accepted
  initial forever begin
    @(negedge clk_i); #1;
    if (ch0_gnt_o) begin
      exp_q0.push_back(exp_align(ch0_addr_i, ch0_datasize_i));
      glog_ch.push_back(0); glog_cyc.push_back(cyc); gcnt0++;
    end
    if (ch1_gnt_o) begin
      exp_q1.push_back(exp_align(ch1_addr_i, ch1_datasize_i));
      glog_ch.push_back(1); glog_cyc.push_back(cyc); gcnt1++;
    end
  end

  // pop monitor: compare head data on every accepted response
  initial forever begin
    @(negedge clk_i); #2;
    if (!rst_i && !clear_i) begin
      if (ch0_valid_o && ch0_ready_i) begin
        chk("ch0_pop_expected", 32'(exp_q0.size() != 0), 1);
        if (exp_q0.size() != 0) chk("ch0_data", ch0_data_o, exp_q0.pop_front());
      end
      if (ch1_valid_o && ch1_ready_i) begin
        chk("ch1_pop_expected", 32'(exp_q1.size() != 0), 1);
        if (exp_q1.size() != 0) chk("ch1_data", ch1_data_o, exp_q1.pop_front());
      end
    end
  end

  // returns at #1 after the negedge of the first ISSUE cycle
  task automatic do_req(input int ch, input logic [14:0] a, input logic [1:0] sz);
    logic got;
    got = 1'b0;
    @(negedge clk_i);
    if (ch == 0) begin ch0_req_i = 1'b1; ch0_addr_i = a; ch0_datasize_i = sz; end
    else         begin ch1_req_i = 1'b1; ch1_addr_i = a; ch1_datasize_i = sz; end
    for (int i = 0; i < 60 && !got; i++) begin
      #1;
      if ((ch == 0) ? ch0_gnt_o : ch1_gnt_o) got = 1'b1;
      else @(negedge clk_i);
    end
    chk($sformatf("ch%0d_granted", ch), 32'(got), 1);
    @(negedge clk_i);
    if (ch == 0) ch0_req_i = 1'b0; else ch1_req_i = 1'b0;
    #1;
    chk("issue_req", 32'(mem_req_o), 1);
    chk("issue_addr", 32'(mem_addr_o), 32'(a[14:2]));
  endtask

  task automatic wait_quiet(input string tag);
    logic done;
    done = 1'b0;
    for (int i = 0; i < 200 && !done; i++) begin
      @(negedge clk_i); #1;
      if (!busy_o) done = 1'b1;
    end
    chk(tag, 32'(done), 1);
  endtask

  task automatic wait_valid0(input string tag);
    logic done;
    done = 1'b0;
    for (int i = 0; i < 40 && !done; i++) begin
      @(negedge clk_i); #1;
      if (ch0_valid_o) done = 1'b1;
    end
    chk(tag, 32'(done), 1);
  endtask

  task automatic do_reset();
    @(negedge clk_i); #2;
    rst_i = 1'b1;
    @(negedge clk_i); @(negedge clk_i); #2;
    rst_i = 1'b0;
    exp_q0.delete(); exp_q1.delete();
  endtask

  initial begin
    logic [31:0] held;
    logic done;

    // reset state, with a pending request that must not be granted
    ch0_req_i = 1'b1;
    #1;
    chk("rst_gnt0", 32'(ch0_gnt_o), 0);
    chk("rst_valid", 32'({ch1_valid_o, ch0_valid_o}), 0);
    chk("rst_mem_req", 32'(mem_req_o), 0);
    chk("rst_busy", 32'(busy_o), 0);
    chk("rst_data0", ch0_data_o, 0);
    chk("rst_mem_addr", 32'(mem_addr_o), 0);
    @(negedge clk_i); @(negedge clk_i);
    ch0_req_i = 1'b0;
    #2 rst_i = 1'b0;

    // byte then halfword read from word 50
    ch0_ready_i = 1'b0;
    do_req(0, 15'd200, 2'b00);
    wait_valid0("byte_valid");
    chk("byte_data", ch0_data_o, 32'h0000_0011);
    ch0_ready_i = 1'b1;
    wait_quiet("byte_quiet");
    do_req(0, 15'd202, 2'b01);
    wait_valid0("half_valid");
    chk("half_data", ch0_data_o, 32'h0000_4433);
    wait_quiet("half_quiet");

    // simultaneous requests after reset: 0,1,0,1 at 3-cycle spacing
    do_reset();
    glog_ch.delete(); glog_cyc.delete();
    @(negedge clk_i);
    ch0_req_i = 1'b1; ch0_addr_i = 15'h0011; ch0_datasize_i = 2'b00;
    ch1_req_i = 1'b1; ch1_addr_i = 15'h0126; ch1_datasize_i = 2'b01;
    done = 1'b0;
    for (int i = 0; i < 60 && !done; i++) begin
      #1;
      if (glog_ch.size() >= 4) done = 1'b1;
      else @(negedge clk_i);
    end
    @(negedge clk_i);
    ch0_req_i = 1'b0; ch1_req_i = 1'b0;
    chk("rr_grants", 32'(glog_ch.size()), 4);
    if (glog_ch.size() >= 4) begin
      chk("rr_order0", 32'(glog_ch[0]), 0);
      chk("rr_order1", 32'(glog_ch[1]), 1);
      chk("rr_order2", 32'(glog_ch[2]), 0);
      chk("rr_order3", 32'(glog_ch[3]), 1);
      chk("rr_spacing1", 32'(glog_cyc[1] - glog_cyc[0]), 3);
      chk("rr_spacing3", 32'(glog_cyc[3] - glog_cyc[2]), 3);
    end
    wait_quiet("rr_quiet");

    // back-pressure: FIFO depth limits grants to 2 until a pop
    ch0_ready_i = 1'b0;
    gcnt0 = 0;
    @(negedge clk_i);
    ch0_req_i = 1'b1; ch0_addr_i = 15'h0104; ch0_datasize_i = 2'b10;
    repeat (20) @(negedge clk_i);
    #1;
    chk("bp_two_grants", 32'(gcnt0), 2);
    chk("bp_valid", 32'(ch0_valid_o), 1);
    held = ch0_data_o;
    repeat (3) @(negedge clk_i);
    #1;
    chk("bp_data_stable", ch0_data_o, held);
    chk("bp_still_two", 32'(gcnt0), 2);
    @(negedge clk_i);
    ch0_ready_i = 1'b1;
    @(negedge clk_i);
    ch0_ready_i = 1'b0;
    done = 1'b0;
    for (int i = 0; i < 20 && !done; i++) begin
      #1;
      if (gcnt0 == 3) done = 1'b1;
      else @(negedge clk_i);
    end
    chk("bp_third_grant", 32'(gcnt0), 3);
    @(negedge clk_i);
    ch0_req_i = 1'b0;
    ch0_ready_i = 1'b1;
    wait_quiet("bp_quiet");

    // delayed memory grant: request/address held, no new grant meanwhile
    gnt_delay = 4;
    do_req(0, 15'h01F8, 2'b10);
    ch1_req_i = 1'b1; ch1_addr_i = 15'h0055; ch1_datasize_i = 2'b00;
    for (int i = 0; i < 4; i++) begin
      if (i > 0) begin @(negedge clk_i); #1; end
      chk("dly_req", 32'(mem_req_o), 1);
      chk("dly_addr", 32'(mem_addr_o), 32'(15'h01F8 >> 2));
      chk("dly_no_gnt", 32'({ch1_gnt_o, ch0_gnt_o}), 0);
    end
    gnt_delay = 0;
    done = 1'b0;
    for (int i = 0; i < 20 && !done; i++) begin
      @(negedge clk_i); #1;
      if (ch1_gnt_o) done = 1'b1;
    end
    chk("dly_ch1_granted", 32'(done), 1);
    @(negedge clk_i);
    ch1_req_i = 1'b0;
    wait_quiet("dly_quiet");

    // clear in WAIT with one entry buffered on ch0
    ch0_ready_i = 1'b0;
    do_req(0, 15'h0040, 2'b10);
    wait_valid0("clr_buffered");
    rsp_lat = 4;
    do_req(1, 15'h0044, 2'b10);
    @(negedge clk_i);
    clear_i = 1'b1;
    exp_q0.delete(); exp_q1.delete();
    @(negedge clk_i);
    clear_i = 1'b0;
    #1;
    chk("clr_fifos_empty", 32'({ch1_valid_o, ch0_valid_o}), 0);
    chk("clr_busy_wait", 32'(busy_o), 1);
    done = 1'b0;
    for (int i = 0; i < 20 && !done; i++) begin
      if (mem_rvalid_i) done = 1'b1;
      else begin @(negedge clk_i); #1; end
    end
    chk("clr_return_seen", 32'(done), 1);
    @(negedge clk_i); #1;
    chk("clr_busy_after", 32'(busy_o), 0);
    chk("clr_discarded", 32'({ch1_valid_o, ch0_valid_o}), 0);
    rsp_lat = 1;
    ch0_ready_i = 1'b1;

    // clear in ISSUE: request stays up until granted, data discarded
    gnt_delay = 3;
    do_req(1, 15'h0123, 2'b01);
    clear_i = 1'b1;
    exp_q0.delete(); exp_q1.delete();
    @(negedge clk_i);
    clear_i = 1'b0;
    #1;
    chk("clr_issue_req_held", 32'(mem_req_o), 1);
    wait_quiet("clr_issue_quiet");
    gnt_delay = 0;

    // reset during ISSUE, then a stray rvalid
    gnt_delay = 5;
    do_req(1, 15'h0300, 2'b10);
    #1 rst_i = 1'b1;
    #1;
    chk("arst_mem_req", 32'(mem_req_o), 0);
    chk("arst_busy", 32'(busy_o), 0);
    chk("arst_mem_addr", 32'(mem_addr_o), 0);
    chk("arst_data1", ch1_data_o, 0);
    exp_q0.delete(); exp_q1.delete();
    @(negedge clk_i); #2;
    rst_i = 1'b0;
    gnt_delay = 0;
    @(negedge clk_i);
    stray_rvalid = 1'b1;
    @(negedge clk_i);
    stray_rvalid = 1'b0;
    #1;
    chk("stray_no_valid", 32'({ch1_valid_o, ch0_valid_o}), 0);
    chk("stray_busy", 32'(busy_o), 0);

    // recovery transaction
    do_req(1, 15'h0203, 2'b00);
    wait_quiet("recover_quiet");

    chk("sb0_drained", 32'(exp_q0.size()), 0);
    chk("sb1_drained", 32'(exp_q1.size()), 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
